// File: rtl/valu_op_sequencer_if.sv
// rtl/valu_op_sequencer_if.sv - request, ALU and response signals of the vector op sequencer
// Ports (grouped):
//   req_valid/req_ready/req_a/req_b/req_sel : op request from decode/issue
//   alu_a/alu_b/alu_sel/alu_result          : operand hold and result from the vector ALU
//   rsp_valid/rsp_ready/rsp_data            : completed lane results to writeback
// Modports: slave = sequencer side, master = surrounding issue/ALU/writeback side.
interface valu_op_sequencer_if #(
  parameter int N = 24,
  parameter int M = 6
);
  logic           req_valid;
  logic           req_ready;
  logic [M*N-1:0] req_a;
  logic [M*N-1:0] req_b;
  logic [3:0]     req_sel;
  logic [M*N-1:0] alu_a;
  logic [M*N-1:0] alu_b;
  logic [3:0]     alu_sel;
  logic [M*N-1:0] alu_result;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [M*N-1:0] rsp_data;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data
  );
endinterface

// File: rtl/valu_op_sequencer.sv
// rtl/valu_op_sequencer.sv - issue controller for the 6-lane vector ALU
// Ports:
//   clk       : single clock, shared with the ALU trig ROMs
//   rst       : asynchronous active-high reset
//   bus       : slave side of valu_op_sequencer_if (request, ALU operands/result, response)
//   busy      : sequencer is not idle
//   op_count  : completed responses, saturating
module valu_op_sequencer #(
  parameter int         N        = 24,
  parameter int         M        = 6,
  parameter logic [3:0] SEL_SIN  = 4'd6,
  parameter logic [3:0] SEL_COS  = 4'd7,
  parameter int         TRIG_LAT = 1,
  parameter int         CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  valu_op_sequencer_if.slave bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);
  localparam int W   = M * N;
  localparam int WCW = (TRIG_LAT > 1) ? $clog2(TRIG_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic             trig_q, trig_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
  logic             accept;

  // Held low during reset so nothing is taken while the datapath is being cleared.
  assign bus.req_ready = ~rst & ((state_q == S_IDLE) | ((state_q == S_RESP) & bus.rsp_ready));
  assign accept        = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    trig_d      = trig_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    op_count_d  = op_count_q;

    case (state_q)
      S_EXEC: begin
        if (trig_q) begin
          // ROM output is registered, so the result is only valid after the wait.
          wait_cnt_d = WCW'(TRIG_LAT - 1);
          state_d    = S_WAIT;
        end else begin
          rsp_data_d  = bus.alu_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          rsp_data_d  = bus.alu_result;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          if (op_count_q != {CNT_W{1'b1}}) begin
            op_count_d = op_count_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or from a completing RESP, so it overrides the
    // state chosen above and gives back-to-back issue without an IDLE bubble.
    if (accept) begin
      alu_a_d   = bus.req_a;
      alu_b_d   = bus.req_b;
      alu_sel_d = bus.req_sel;
      trig_d    = (bus.req_sel == SEL_SIN) | (bus.req_sel == SEL_COS);
      state_d   = S_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      trig_q      <= 1'b0;
      wait_cnt_q  <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      trig_q      <= trig_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign op_count      = op_count_q;
endmodule

// File: tb/tb_valu_op_sequencer.sv
// tb/tb_valu_op_sequencer.sv - scoreboard bench for valu_op_sequencer
module tb_valu_op_sequencer;
  localparam int         N       = 24;
  localparam int         M       = 6;
  localparam int         W       = M * N;
  localparam int         CNT_W   = 16;
  localparam logic [3:0] SEL_SIN = 4'd6;
  localparam logic [3:0] SEL_COS = 4'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  int               errors = 0;
  int               checks = 0;
  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     rom_q;

  always #5 clk = ~clk;

  valu_op_sequencer_if #(.N(N), .M(M)) bus ();

  valu_op_sequencer #(
    .N(N), .M(M), .SEL_SIN(SEL_SIN), .SEL_COS(SEL_COS), .TRIG_LAT(1), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .op_count(op_count)
  );

  // 12-bit signed trig table, sign-extended to the lane width.
  function automatic logic [N-1:0] rom_word(input logic [5:0] addr);
    logic [11:0] w;
    w = {~addr[5], addr[4:0], addr ^ 6'h2A};
    return {{(N-12){w[11]}}, w};
  endfunction

  function automatic logic [N-1:0] alu_lane(input logic [3:0] sel, input logic [N-1:0] a, input logic [N-1:0] b);
    case (sel)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      SEL_SIN: return rom_word(b[5:0]);
      SEL_COS: return rom_word(b[5:0] + 6'd16);
      default: return a & b;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic [3:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < M; k++) r[k*N +: N] = alu_lane(sel, a[k*N +: N], b[k*N +: N]);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < M; k++) r[k*N +: N] = N'($urandom);
    return r;
  endfunction

  // ALU model: trig lanes come from a ROM registered on clk, everything else is combinational.
  always @(posedge clk) begin
    for (int k = 0; k < M; k++) rom_q[k*N +: N] <= alu_lane(bus.alu_sel, '0, bus.alu_b[k*N +: N]);
  end

  always_comb begin
    bus.alu_result = '0;
    for (int k = 0; k < M; k++) begin
      if (bus.alu_sel == SEL_SIN || bus.alu_sel == SEL_COS)
        bus.alu_result[k*N +: N] = rom_q[k*N +: N];
      else
        bus.alu_result[k*N +: N] = alu_lane(bus.alu_sel, bus.alu_a[k*N +: N], bus.alu_b[k*N +: N]);
    end
  end

  task automatic set_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sel   = sel;
    exp_q.push_back(exp_vec(sel, a, b));
  endtask

  // Returns at the negedge after the accept edge with req_valid dropped.
  task automatic drive_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel);
    set_req(a, b, sel);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Cycles from the accept edge until rsp_valid is seen; -1 on timeout.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (bus.rsp_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.rsp_valid !== 1'b1) cyc = -1;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] b;
    logic         seen;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_data, bus.rsp_valid, op_count, bus.req_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: alu_sel=%h rsp_valid=%b op_count=%0d req_ready=%b, want all 0",
               bus.alu_sel, bus.rsp_valid, op_count, bus.req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b want 1", bus.req_ready); end
    b = '0;
    for (int k = 0; k < M; k++) b[k*N +: 6] = 6'(k + 3);
    drive_req(rand_vec(), b, SEL_SIN);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL in_wait: busy=%b rsp_valid=%b want 1/0", busy, bus.rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.rsp_data, bus.rsp_valid, op_count, bus.req_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait: alu_sel=%h rsp_valid=%b busy=%b req_ready=%b, want all 0",
               bus.alu_sel, bus.rsp_valid, busy, bus.req_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rerelease: got %b want 1", bus.req_ready); end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || op_count !== '0) begin
      errors++; $display("FAIL dropped_op: rsp seen=%b op_count=%0d want 0/0", seen, op_count);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] a, b;
    int           cyc;
    for (int k = 0; k < M; k++) begin
      a[k*N +: N] = N'(k + 1);
      b[k*N +: N] = N'(10);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", bus.req_ready); end
    drive_req(a, b, 4'd0);
    checks++;
    if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_sel !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL add_operands: alu_a=%h alu_sel=%h busy=%b want %h/0/1", bus.alu_a, bus.alu_sel, busy, a);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", cyc); end
    checks++;
    if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0]) begin
      errors++; $display("FAIL add_data: got %h want %h", bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    checks++;
    if (bus.rsp_data[N-1:0] !== N'(11) || bus.rsp_data[W-1 -: N] !== N'(16)) begin
      errors++; $display("FAIL add_lanes: lane0=%0d lane5=%0d want 11/16", bus.rsp_data[N-1:0], bus.rsp_data[W-1 -: N]);
    end
    handshake();
    checks++;
    if (op_count !== CNT_W'(1) || bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL add_done: op_count=%0d rsp_valid=%b busy=%b want 1/0/0", op_count, bus.rsp_valid, busy);
    end
  endtask

  task automatic test_trig();
    logic [W-1:0] a, b;
    int           cyc;
    a = rand_vec();
    b = rand_vec();
    for (int k = 0; k < M; k++) b[k*N +: 6] = 6'd16;
    drive_req(a, b, SEL_SIN);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_b !== b) begin
      errors++; $display("FAIL sin_exec: rsp_valid=%b alu_b=%h want 0/%h", bus.rsp_valid, bus.alu_b, b);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.alu_b !== b || busy !== 1'b1) begin
      errors++; $display("FAIL sin_wait: rsp_valid=%b busy=%b alu_b=%h want 0/1/%h", bus.rsp_valid, busy, bus.alu_b, b);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.alu_b !== b) begin
      errors++; $display("FAIL sin_latency: rsp_valid=%b at T0+2 want 1", bus.rsp_valid);
    end
    checks++;
    if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0] || bus.rsp_data[N-1:0] !== rom_word(6'd16)) begin
      errors++; $display("FAIL sin_data: got %h want %h", bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    handshake();
    b = rand_vec();
    drive_req(rand_vec(), b, SEL_COS);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL cos_latency: got %0d want 2", cyc); end
    checks++;
    if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0]) begin
      errors++; $display("FAIL cos_data: got %h want %h", bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    handshake();
    checks++;
    if (op_count !== CNT_W'(3)) begin errors++; $display("FAIL trig_count: got %0d want 3", op_count); end
  endtask

  task automatic test_other_sel();
    logic [3:0] sels [5];
    int         cyc;
    sels = '{4'd1, 4'd2, 4'd5, 4'd9, 4'd15};
    for (int i = 0; i < 5; i++) begin
      drive_req(rand_vec(), rand_vec(), sels[i]);
      wait_rsp(cyc);
      checks++;
      if (cyc !== 1) begin errors++; $display("FAIL sel%0d_latency: got %0d want 1", sels[i], cyc); end
      checks++;
      if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0]) begin
        errors++; $display("FAIL sel%0d_data: got %h want %h", sels[i], bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held, a_held;
    int           cyc;
    logic         bad;
    drive_req(rand_vec(), rand_vec(), 4'd0);
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL bp_latency: got %0d want 1", cyc); end
    held   = exp_q.size() != 0 ? exp_q[0] : '0;
    a_held = bus.alu_a;
    bus.req_valid = 1'b1;
    bus.req_a     = rand_vec();
    bus.req_b     = rand_vec();
    bus.req_sel   = 4'd2;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== held || bus.req_ready !== 1'b0 || bus.alu_a !== a_held) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL bp_hold: rsp_valid=%b req_ready=%b data=%h want 1/0/%h", bus.rsp_valid, bus.req_ready, bus.rsp_data, held);
    end
    bus.req_valid = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    handshake();
    checks++;
    if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_no_second_accept: busy=%b rsp_valid=%b want 0/0", busy, bus.rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]     a2;
    logic [CNT_W-1:0] cnt_before;
    int               cyc;
    drive_req(rand_vec(), rand_vec(), 4'd1);
    wait_rsp(cyc);
    a2 = rand_vec();
    bus.rsp_ready = 1'b1;
    set_req(a2, rand_vec(), 4'd0);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
    checks++;
    if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0]) begin
      errors++; $display("FAIL b2b_first_data: got %h want %h", bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    cnt_before = op_count;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.rsp_valid !== 1'b0 || op_count !== cnt_before + CNT_W'(1) || bus.alu_a !== a2) begin
      errors++; $display("FAIL b2b_accept: busy=%b rsp_valid=%b op_count=%0d alu_a=%h want 1/0/%0d/%h",
                         busy, bus.rsp_valid, op_count, bus.alu_a, cnt_before + CNT_W'(1), a2);
    end
    wait_rsp(cyc);
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL b2b_latency: got %0d want 1", cyc); end
    checks++;
    if (exp_q.size() == 0 || bus.rsp_data !== exp_q[0]) begin
      errors++; $display("FAIL b2b_second_data: got %h want %h", bus.rsp_data, (exp_q.size() != 0) ? exp_q[0] : 'x);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    handshake();
  endtask

  task automatic test_saturate();
    int cyc;
    force dut.op_count_q = {CNT_W{1'b1}};
    @(negedge clk);
    release dut.op_count_q;
    checks++;
    if (op_count !== {CNT_W{1'b1}}) begin errors++; $display("FAIL sat_preset: got %h want all ones", op_count); end
    drive_req(rand_vec(), rand_vec(), 4'd0);
    wait_rsp(cyc);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    handshake();
    checks++;
    if (op_count !== {CNT_W{1'b1}}) begin errors++; $display("FAIL sat_hold: got %h want all ones", op_count); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_trig();
    test_other_sel();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
